channel_scan_sequencer: RTL and testbench

//  Upstream driver for the 4-to-16 channel decoder. Steps through 16 channels and skips those

---
 rtl/scan_pkg.sv | 29 ++
 rtl/channel_scan_sequencer_if.sv | 35 +++
 rtl/scan_dwell_counter.sv | 43 ++++
 rtl/channel_scan_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_channel_scan_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the channel scan sequencer: FSM state encoding,
// select width / channel count constants and the select bit-reversal helper
// that maps a channel index onto the decoder's input bit order.
// No ports (package).
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int SEL_W = 4;
  localparam int N_CH  = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The decoder expects the channel MSB on sel[0], so the index is mirrored.
  function automatic logic [SEL_W-1:0] bitrev(input logic [SEL_W-1:0] i_v);
    logic [SEL_W-1:0] w_rev;
    for (int i = 0; i < SEL_W; i++) begin
      w_rev[i] = i_v[SEL_W-1-i];
    end
    return w_rev;
  endfunction

endpackage

// File: rtl/channel_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// channel_scan_sequencer_if
// Control/select bundle between a sweep controller plus decoder consumer
// (master side) and the channel scan sequencer (slave side).
//   start, stop, cont, mask, dwell, sel_ready : master -> sequencer
//   sel, sel_valid, ch_done, sweep_done, busy : sequencer -> master
// -----------------------------------------------------------------------------
interface channel_scan_sequencer_if #(
  parameter int SEL_W   = scan_pkg::SEL_W,
  parameter int DWELL_W = 8
);

  logic                  start;
  logic                  stop;
  logic                  cont;
  logic [2**SEL_W-1:0]   mask;
  logic [DWELL_W-1:0]    dwell;
  logic                  sel_ready;
  logic [SEL_W-1:0]      sel;
  logic                  sel_valid;
  logic                  ch_done;
  logic                  sweep_done;
  logic                  busy;

  modport master (
    output start, stop, cont, mask, dwell, sel_ready,
    input  sel, sel_valid, ch_done, sweep_done, busy
  );

  modport slave (
    input  start, stop, cont, mask, dwell, sel_ready,
    output sel, sel_valid, ch_done, sweep_done, busy
  );

endinterface

// File: rtl/scan_dwell_counter.sv
// -----------------------------------------------------------------------------
// scan_dwell_counter
// Load/decrement down-counter that measures how long a channel has been held.
// The count saturates at zero; o_expired is high whenever the count is zero.
//   i_clk      : clock, rising edge
//   i_rst      : synchronous reset, active-high (count -> 0)
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one if not already zero
//   o_expired  : count == 0
// -----------------------------------------------------------------------------
module scan_dwell_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_expired
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Dwell count register: load, saturating decrement, or hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/channel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// channel_scan_sequencer
// Drives the 4-to-16 channel decoder: walks channels 0..15, skipping those
// disabled in the latched mask, holds each enabled channel for the latched
// dwell time and leaves it only once the consumer is ready. Optionally
// restarts the sweep after each pass.
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, active-high
//   bus   : slave side of channel_scan_sequencer_if
//           (start/stop/cont/mask/dwell/sel_ready in,
//            sel/sel_valid/ch_done/sweep_done/busy out)
// All outputs are registered except ch_done, which is combinational from
// registers and sel_ready.
// -----------------------------------------------------------------------------
module channel_scan_sequencer #(
  parameter int SEL_W   = scan_pkg::SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  channel_scan_sequencer_if.slave bus
);

  import scan_pkg::*;

  localparam int                 NCH       = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]   CH_ZERO   = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0]   CH_ONE    = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]   CH_LAST   = {SEL_W{1'b1}};
  localparam logic [DWELL_W-1:0] DW_ZERO   = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DW_ONE    = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [NCH-1:0]     MASK_ZERO = {NCH{1'b0}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_ch;
  logic [SEL_W-1:0]   w_ch_nxt;
  logic [NCH-1:0]     r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_cont;
  logic               w_latch;
  logic               w_cnt_load;
  logic               w_cnt_dec;
  logic               w_cnt_expired;
  logic [DWELL_W-1:0] w_cnt_load_val;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_sel_valid;
  logic               w_sel_valid_nxt;
  logic               r_sweep_done;
  logic               w_sweep_done_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  // A dwell of 0 behaves like 1, so the counter is loaded with max(dwell,1)-1.
  assign w_cnt_load_val = (r_dwell == DW_ZERO) ? DW_ZERO : (r_dwell - DW_ONE);
  assign w_cnt_dec      = (r_state == DWELL);

  scan_dwell_counter #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_expired  (w_cnt_expired)
  );

  // Sweep configuration: captured only when a sweep is accepted from IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask  <= MASK_ZERO;
      r_dwell <= DW_ZERO;
      r_cont  <= 1'b0;
    end else if (w_latch) begin
      r_mask  <= bus.mask;
      r_dwell <= bus.dwell;
      r_cont  <= bus.cont;
    end else begin
      r_mask  <= r_mask;
      r_dwell <= r_dwell;
      r_cont  <= r_cont;
    end
  end

  // State and channel index registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ch    <= CH_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // Next-state, channel advance and counter load decode; stop overrides all
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_latch     = 1'b0;
    w_cnt_load  = 1'b0;
    if (bus.stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            w_latch     = 1'b1;
            w_ch_nxt    = CH_ZERO;
            w_state_nxt = (bus.mask != MASK_ZERO) ? SEEK : DONE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        SEEK: begin
          if (r_mask[r_ch]) begin
            w_state_nxt = DWELL;
            w_cnt_load  = 1'b1;
          end else if (r_ch == CH_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_ch_nxt    = r_ch + CH_ONE;
            w_state_nxt = SEEK;
          end
        end
        DWELL: begin
          if (w_cnt_expired && bus.sel_ready) begin
            if (r_ch == CH_LAST) begin
              w_state_nxt = DONE;
            end else begin
              w_ch_nxt    = r_ch + CH_ONE;
              w_state_nxt = SEEK;
            end
          end else begin
            w_state_nxt = DWELL;
          end
        end
        DONE: begin
          if (r_cont) begin
            w_ch_nxt    = CH_ZERO;
            w_state_nxt = SEEK;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs line up with the state
  always_comb begin
    w_sel_valid_nxt  = (w_state_nxt == DWELL);
    w_sweep_done_nxt = (w_state_nxt == DONE);
    w_busy_nxt       = (w_state_nxt != IDLE);
    if (w_state_nxt == DWELL) begin
      w_sel_nxt = bitrev(w_ch_nxt);
    end else begin
      w_sel_nxt = r_sel;
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel        <= CH_ZERO;
      r_sel_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_sel_valid  <= w_sel_valid_nxt;
      r_sweep_done <= w_sweep_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign bus.sel        = r_sel;
  assign bus.sel_valid  = r_sel_valid;
  assign bus.sweep_done = r_sweep_done;
  assign bus.busy       = r_busy;
  assign bus.ch_done    = r_sel_valid & w_cnt_expired & bus.sel_ready;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_channel_scan_sequencer
// Self-checking bench for channel_scan_sequencer: a table of full sweeps with
// a scoreboard of expected select codes, plus hand-written sequences for
// back-pressure, continuous mode, stop, start/stop collision and reset.
// -----------------------------------------------------------------------------
module tb_channel_scan_sequencer;

  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;
  localparam int N_CH    = 16;

  typedef struct {
    logic [15:0] mask;
    logic [7:0]  dwell;
    int          exp_busy;
    int          exp_first;
    int          exp_ndone;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  channel_scan_sequencer_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  channel_scan_sequencer #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  function automatic logic [3:0] tb_bitrev(input int ch);
    logic [3:0] c;
    c = ch[3:0];
    return {c[0], c[1], c[2], c[3]};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    bit  idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      adv();
      smp();
      idle = !bus.busy;
      n++;
    end
    check("idle_reached", int'(idle), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, busy_cyc, first, n_done, n_sweep, run_len, exp_len;
    bit fin;
    sb_q.delete();
    for (int c = 0; c < N_CH; c++) begin
      if (v.mask[c]) sb_q.push_back(tb_bitrev(c));
    end
    exp_len  = (v.dwell == 8'd0) ? 1 : int'(v.dwell);
    cyc      = 1;
    busy_cyc = 0;
    first    = 0;
    n_done   = 0;
    n_sweep  = 0;
    run_len  = 0;
    fin      = 1'b0;
    adv();
    bus.mask      = v.mask;
    bus.dwell     = v.dwell;
    bus.cont      = 1'b0;
    bus.sel_ready = 1'b1;
    bus.start     = 1'b1;
    adv();
    bus.start = 1'b0;
    while (!fin && cyc < 400) begin
      smp();
      if (bus.sel_valid) begin
        if (first == 0) first = cyc;
        run_len++;
      end else if (run_len != 0) begin
        check("dwell_len", run_len, exp_len);
        run_len = 0;
      end
      if (bus.ch_done) begin
        n_done++;
        check("sb_nonempty", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check("sb_sel", int'(bus.sel), int'(sb_q.pop_front()));
      end
      if (bus.sweep_done) n_sweep++;
      if (bus.busy) busy_cyc++;
      else fin = 1'b1;
      if (!fin) begin
        adv();
        cyc++;
      end
    end
    check("sweep_end", int'(fin), 1);
    check("busy_cycles", busy_cyc, v.exp_busy);
    check("first_valid", first, v.exp_first);
    check("ch_done_cnt", n_done, v.exp_ndone);
    check("sweep_done_cnt", n_sweep, 1);
    check("sb_left", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rise[3];
    int   nr, n_sw, cyc, busy_cyc, n_done;
    logic prev;

    // mask, dwell, busy clocks, first sel_valid clock, accepted channels
    vecs[0] = '{16'h0005, 8'd2,   21,  2,  2};
    vecs[1] = '{16'h0001, 8'd1,   18,  2,  1};
    vecs[2] = '{16'h0000, 8'd3,    1,  0,  0};
    vecs[3] = '{16'h8000, 8'd1,   18, 17,  1};
    vecs[4] = '{16'hFFFF, 8'd0,   33,  2, 16};
    vecs[5] = '{16'hA5A5, 8'd3,   41,  2,  8};
    vecs[6] = '{16'h0100, 8'd255, 272, 10,  1};
    vecs[7] = '{16'h1000, 8'd4,   21, 14,  1};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cont      = 1'b0;
    bus.mask      = 16'h0000;
    bus.dwell     = 8'd0;
    bus.sel_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    check("rst_sel", int'(bus.sel), 0);
    check("rst_sel_valid", int'(bus.sel_valid), 0);
    check("rst_ch_done", int'(bus.ch_done), 0);
    check("rst_sweep_done", int'(bus.sweep_done), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Table-driven full sweeps
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-pressure: dwell expired but consumer not ready for 5 clocks
    adv();
    bus.mask = 16'h0001; bus.dwell = 8'd1; bus.cont = 1'b0;
    bus.sel_ready = 1'b0; bus.start = 1'b1;
    adv();
    bus.start = 1'b0;
    adv();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adv();
      smp();
      check("bp_valid_held", int'(bus.sel_valid), 1);
      check("bp_no_ch_done", int'(bus.ch_done), 0);
    end
    adv();
    bus.sel_ready = 1'b1;
    smp();
    check("bp_ch_done", int'(bus.ch_done), 1);
    check("bp_sel", int'(bus.sel), 0);
    wait_idle(40);

    // Continuous mode; mid-sweep changes to cont and mask must have no effect
    adv();
    bus.mask = 16'h8000; bus.dwell = 8'd1; bus.cont = 1'b1;
    bus.sel_ready = 1'b1; bus.start = 1'b1;
    adv();
    bus.start = 1'b0; bus.cont = 1'b0; bus.mask = 16'h0000;
    cyc  = 1;
    nr   = 0;
    n_sw = 0;
    prev = 1'b0;
    while (nr < 3 && cyc < 100) begin
      smp();
      if (bus.sel_valid && !prev) begin
        rise[nr] = cyc;
        check("cont_sel", int'(bus.sel), 15);
        nr++;
      end
      if (bus.sweep_done) n_sw++;
      prev = bus.sel_valid;
      if (nr < 3) begin
        adv();
        cyc++;
      end
    end
    check("cont_rises", nr, 3);
    if (nr == 3) begin
      check("cont_first", rise[0], 17);
      check("cont_period1", rise[1] - rise[0], 18);
      check("cont_period2", rise[2] - rise[1], 18);
      check("cont_sweeps", n_sw, 2);
      // Still inside the third dwell: stop before its closing edge
      bus.stop = 1'b1;
      adv();
      bus.stop = 1'b0;
      smp();
      check("stop_valid", int'(bus.sel_valid), 0);
      check("stop_busy", int'(bus.busy), 0);
      check("stop_sweep_done", int'(bus.sweep_done), 0);
      repeat (3) adv();
      smp();
      check("stop_stays_idle", int'(bus.busy), 0);
    end

    // start and stop in the same clock: stop wins
    adv();
    bus.mask = 16'hFFFF; bus.dwell = 8'd1; bus.start = 1'b1; bus.stop = 1'b1;
    adv();
    bus.start = 1'b0; bus.stop = 1'b0;
    smp();
    check("ss_busy", int'(bus.busy), 0);
    check("ss_valid", int'(bus.sel_valid), 0);
    adv();
    smp();
    check("ss_busy_later", int'(bus.busy), 0);

    // start during DWELL is ignored, new mask/dwell not taken
    adv();
    bus.mask = 16'h0001; bus.dwell = 8'd4; bus.sel_ready = 1'b1; bus.start = 1'b1;
    adv();
    bus.start = 1'b0;
    adv();
    smp();
    check("sd_in_dwell", int'(bus.sel_valid), 1);
    adv();
    bus.start = 1'b1; bus.mask = 16'hFFFF; bus.dwell = 8'd1;
    adv();
    bus.start = 1'b0;
    busy_cyc = 0;
    n_done   = 0;
    cyc      = 0;
    smp();
    while (bus.busy && cyc < 100) begin
      busy_cyc++;
      if (bus.ch_done) n_done++;
      adv();
      smp();
      cyc++;
    end
    check("sd_remaining_busy", busy_cyc, 18);
    check("sd_ch_done", n_done, 1);

    // Reset during DWELL
    adv();
    bus.mask = 16'h0002; bus.dwell = 8'd5; bus.start = 1'b1;
    adv();
    bus.start = 1'b0;
    adv();
    adv();
    smp();
    check("rd_valid", int'(bus.sel_valid), 1);
    check("rd_sel", int'(bus.sel), 8);
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    smp();
    check("rd_sel0", int'(bus.sel), 0);
    check("rd_valid0", int'(bus.sel_valid), 0);
    check("rd_busy0", int'(bus.busy), 0);
    check("rd_sweep_done0", int'(bus.sweep_done), 0);
    check("rd_ch_done0", int'(bus.ch_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
